// File: rtl/mem_io_bridge.sv
// mem_io_bridge: data-side bridge between the CPU Mem-stage port and data RAM / I/O.
//   RAM space (cpu_addr[31:28] != 4'hF): req/ack handshake with a timeout that sets a
//   sticky bus error. I/O space (cpu_addr[31:28] == 4'hF): zero-wait LED, free-running
//   timer and status registers.
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   Mem-stage access request (load or store)
//   cpu_rdata/cpu_ready          load data and completion (0 = stall pipeline)
//   ram_req/ram_we/ram_addr/ram_wdata   RAM request, held until ack or timeout
//   ram_rdata/ram_ack            RAM read data and completion strobe
//   led_out                      LED register
//   bus_err                      sticky RAM-timeout flag, cleared by a STATUS write
module mem_io_bridge #(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack,
  output logic [15:0]           led_out,
  output logic                  bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRamWait, StDone} state_e;

  state_e          state;
  logic [CntW-1:0] wait_cnt;
  logic [CntW-1:0] wait_cnt_inc;
  logic [31:0]     timer;
  logic [31:0]     rdata_q;
  logic [31:0]     io_rdata;
  logic            is_io;
  logic [1:0]      io_sel;
  logic            io_wr;
  logic            ram_start;

  // Address bits outside the decode and RAM word index do not matter.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr[27:RAM_ADDR_W+2], cpu_addr[1:0]};

  assign is_io        = (cpu_addr[31:28] == 4'hF);
  assign io_sel       = cpu_addr[3:2];  // byte offsets 0x0/0x4/0x8/0xC
  assign io_wr        = (state == StIdle) && cpu_req && is_io && cpu_we;
  assign ram_start    = (state == StIdle) && cpu_req && !is_io;
  assign wait_cnt_inc = wait_cnt + CntW'(1);

  always_comb begin
    io_rdata = 32'h0;
    case (io_sel)
      2'd0:    io_rdata = {16'h0, led_out};
      2'd1:    io_rdata = timer;
      2'd2:    io_rdata = {31'h0, bus_err};
      default: io_rdata = 32'h0;
    endcase
  end

  // I/O accesses complete combinationally in IDLE; RAM accesses stall until DONE.
  always_comb begin
    cpu_ready = 1'b1;
    cpu_rdata = 32'h0;
    if (!rst) begin
      case (state)
        StIdle: begin
          if (cpu_req) begin
            if (is_io) cpu_rdata = io_rdata;
            else       cpu_ready = 1'b0;
          end
        end
        StRamWait: cpu_ready = 1'b0;
        StDone:    cpu_rdata = rdata_q;
        default:   cpu_ready = 1'b1;
      endcase
    end
  end

  // Handshake FSM with registered RAM-side outputs and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      wait_cnt  <= '0;
      rdata_q   <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (io_wr && (io_sel == 2'd2)) bus_err <= 1'b0;
          if (ram_start) begin
            ram_req   <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr[RAM_ADDR_W+1:2];
            ram_wdata <= cpu_wdata;
            wait_cnt  <= '0;
            state     <= StRamWait;
          end
        end
        StRamWait: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (ram_ack) begin
            rdata_q <= ram_we ? 32'h0 : ram_rdata;
            ram_req <= 1'b0;
            state   <= StDone;
          end else if (wait_cnt_inc == CntW'(TIMEOUT)) begin
            rdata_q <= 32'h0;
            ram_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= StDone;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // LED and timer registers; a timer write overrides that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= 16'h0;
      timer   <= 32'h0;
    end else begin
      if (io_wr && (io_sel == 2'd0)) led_out <= cpu_wdata[15:0];
      if (io_wr && (io_sel == 2'd1)) timer <= cpu_wdata;
      else                           timer <= timer + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        ram_req;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic [15:0] led_out;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mem_m [1024];
  logic [15:0] led_m;
  logic [31:0] timer_m;
  logic        err_m;
  bit          tmr_wr_pend;
  logic [31:0] tmr_wr_val;

  mem_io_bridge #(.RAM_ADDR_W(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .led_out(led_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock (ends just after the falling edge) and step the timer model.
  task automatic tick();
    if (rst)              timer_m = 32'h0;
    else if (tmr_wr_pend) timer_m = tmr_wr_val;
    else                  timer_m = timer_m + 32'd1;
    tmr_wr_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] io_model(input logic [3:0] off);
    case (off)
      4'h0:    return {16'h0, led_m};
      4'h4:    return timer_m;
      4'h8:    return {31'h0, err_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic io_access(input bit we, input logic [3:0] off, input logic [31:0] wdata);
    logic [31:0] r;
    r = $urandom;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = {4'hF, r[23:0], off};
    cpu_wdata = wdata;
    // Stray acks outside a RAM wait must have no effect.
    ram_ack   = 1'($urandom_range(0, 1));
    ram_rdata = $urandom;
    #1;
    chk("io_ready", {31'h0, cpu_ready}, 32'h1);
    if (!we) chk("io_rdata", cpu_rdata, io_model(off));
    if (we) begin
      if (off == 4'h0) led_m = wdata[15:0];
      if (off == 4'h4) begin tmr_wr_pend = 1'b1; tmr_wr_val = wdata; end
      if (off == 4'h8) err_m = 1'b0;
    end
    tick();
    cpu_req = 1'b0;
    ram_ack = 1'b0;
    #1;
    chk("led_out", {16'h0, led_out}, {16'h0, led_m});
    chk("bus_err_io", {31'h0, bus_err}, {31'h0, err_m});
  endtask

  // ack_at: RAM-wait cycle (1-based) in which ack is given; 0 means never.
  task automatic ram_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_at);
    logic [9:0]  idx;
    logic [31:0] exp;
    bit          acked;
    idx       = addr[11:2];
    acked     = 1'b0;
    exp       = 32'h0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    chk("ram_issue_ready", {31'h0, cpu_ready}, 32'h0);
    chk("ram_issue_req", {31'h0, ram_req}, 32'h0);
    tick();
    for (int n = 1; n <= TIMEOUT; n++) begin
      #1;
      chk("wait_req", {31'h0, ram_req}, 32'h1);
      chk("wait_ready", {31'h0, cpu_ready}, 32'h0);
      chk("ram_addr", {22'h0, ram_addr}, {22'h0, idx});
      chk("ram_we", {31'h0, ram_we}, {31'h0, we});
      if (we) chk("ram_wdata", ram_wdata, wdata);
      if (n == ack_at) begin
        ram_ack = 1'b1;
        if (we) begin
          ram_rdata  = $urandom;
          mem_m[idx] = wdata;
        end else begin
          ram_rdata = mem_m[idx];
          exp       = mem_m[idx];
        end
        acked = 1'b1;
      end
      tick();
      ram_ack = 1'b0;
      if (acked) break;
    end
    if (!acked) err_m = 1'b1;
    #1;
    chk("done_ready", {31'h0, cpu_ready}, 32'h1);
    chk("done_rdata", cpu_rdata, exp);
    chk("done_req", {31'h0, ram_req}, 32'h0);
    chk("done_bus_err", {31'h0, bus_err}, {31'h0, err_m});
    cpu_req = 1'b0;
    tick();
    #1;
    chk("idle_ready", {31'h0, cpu_ready}, 32'h1);
    chk("idle_rdata", cpu_rdata, 32'h0);
  endtask

  function automatic logic [31:0] rand_ram_addr();
    logic [31:0] a;
    a        = $urandom;
    a[31:28] = 4'($urandom_range(0, 14));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
    led_m       = 16'h0;
    timer_m     = 32'h0;
    err_m       = 1'b0;
    tmr_wr_pend = 1'b0;
    tmr_wr_val  = 32'h0;
    rst         = 1'b1;
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_addr    = 32'h0000_0100;
    cpu_wdata   = 32'h0;
    ram_rdata   = 32'h0;
    ram_ack     = 1'b0;

    // Reset state, with a RAM request pending that must not stall.
    @(negedge clk);
    #1;
    chk("rst_ready", {31'h0, cpu_ready}, 32'h1);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ram_req", {31'h0, ram_req}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    tick();
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("idle_ready0", {31'h0, cpu_ready}, 32'h1);
    io_access(1'b0, 4'h4, 32'h0);

    // LED write then read back.
    io_access(1'b1, 4'h0, 32'h1234_ABCD);
    chk("led_abcd", {16'h0, led_out}, 32'h0000_ABCD);
    io_access(1'b0, 4'h0, 32'h0);

    // RAM store acked in the 2nd wait cycle, then load acked in the 1st.
    ram_access(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 2);
    mem_m[2] = 32'h55AA_55AA;
    ram_access(1'b0, 32'h0000_0008, 32'h0, 1);
    ram_access(1'b0, 32'h0000_0010, 32'h0, 3);

    // Timeout, status read, status clear; then ack exactly in the last wait cycle.
    ram_access(1'b0, 32'h0000_0020, 32'h0, 0);
    io_access(1'b0, 4'h8, 32'h0);
    io_access(1'b1, 4'h8, 32'h0);
    io_access(1'b0, 4'h8, 32'h0);
    ram_access(1'b0, 32'h0000_0024, 32'h0, TIMEOUT);
    chk("ack_wins", {31'h0, bus_err}, 32'h0);

    // Timer wrap and unmapped offset.
    io_access(1'b1, 4'h4, 32'hFFFF_FFFE);
    io_access(1'b0, 4'h4, 32'h0);
    io_access(1'b0, 4'h4, 32'h0);
    io_access(1'b0, 4'h4, 32'h0);
    chk("timer_wrapped", timer_m, 32'h0000_0001);
    io_access(1'b1, 4'hC, 32'hDEAD_BEEF);
    io_access(1'b0, 4'hC, 32'h0);

    // Randomized mix of I/O and RAM traffic.
    for (int it = 0; it < 200; it++) begin
      int kind;
      int ack_at;
      logic [3:0] off;
      kind = $urandom_range(0, 5);
      off  = 4'($urandom_range(0, 3) * 4);
      if (kind == 0) begin
        io_access(1'b0, off, 32'h0);
      end else if (kind == 1) begin
        io_access(1'b1, off, $urandom);
      end else if (kind == 2) begin
        cpu_req = 1'b0;
        #1;
        chk("rand_idle_ready", {31'h0, cpu_ready}, 32'h1);
        chk("rand_idle_rdata", cpu_rdata, 32'h0);
        tick();
      end else begin
        ack_at = $urandom_range(1, TIMEOUT + 3);
        if (ack_at > TIMEOUT) ack_at = 0;
        ram_access(1'($urandom_range(0, 1)), rand_ram_addr(), $urandom, ack_at);
      end
    end

    // Reset in the middle of a RAM wait abandons the transaction.
    io_access(1'b1, 4'h0, 32'h0000_5A5A);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0040;
    tick();
    tick();
    tick();
    #1;
    chk("pre_rst_req", {31'h0, ram_req}, 32'h1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    led_m   = 16'h0;
    err_m   = 1'b0;
    timer_m = 32'h0;
    tmr_wr_pend = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, ram_req}, 32'h0);
    chk("mid_rst_ready", {31'h0, cpu_ready}, 32'h1);
    chk("mid_rst_rdata", cpu_rdata, 32'h0);
    chk("mid_rst_led", {16'h0, led_out}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    ram_access(1'b0, 32'h0000_0040, 32'h0, 2);
    io_access(1'b0, 4'h4, 32'h0);
    io_access(1'b0, 4'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
